pattern_evt_capture: RTL

//  Downstream consumer of the merged pattern stage (pattern_5_4 family): samples its 8 outputs
//  (N1508_0, N6147_2, n_429_or_0_5, G78_5, n_576_5, n_547_5, N1507_6, N1508_6) every clock.

---
 rtl/pattern_evt_capture_pkg.sv | 24 ++
 rtl/pattern_evt_capture_if.sv | 33 +++
 rtl/pattern_evt_capture_fifo.sv | 44 ++++
 rtl/pattern_evt_capture.sv | 116 +++++++++++
 4 files changed

// File: rtl/pattern_evt_capture_pkg.sv
// Shared types and defaults for the pattern event capture block.
// Optional timestamp field in cap_entry_t is controlled by PATTERN_TSTAMP_EN.
package pattern_cap_pkg;

    localparam int CAP_VEC_W  = 8;
    localparam int CAP_DEPTH  = 8;
    localparam int CAP_TS_W   = 16;
    localparam int CAP_DROP_W = 8;
    localparam int PTR_W      = $clog2(CAP_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } cap_state_e;

    typedef struct packed {
`ifdef PATTERN_TSTAMP_EN
        logic [CAP_TS_W-1:0]  ts;
`endif
        logic [CAP_VEC_W-1:0] vec;
    } cap_entry_t;

endpackage

// File: rtl/pattern_evt_capture_if.sv
// Event stream from pattern_evt_capture to its sink (valid/ready).
// evt_ts exists only when PATTERN_TSTAMP_EN is defined.
interface pattern_evt_capture_if #(
    parameter int VEC_W = 8
`ifdef PATTERN_TSTAMP_EN
    , parameter int TS_W = 16
`endif
);
    logic             evt_valid;
    logic             evt_ready;
    logic [VEC_W-1:0] evt_vec;
`ifdef PATTERN_TSTAMP_EN
    logic [TS_W-1:0]  evt_ts;
`endif

    modport master (
        output evt_valid,
        output evt_vec,
`ifdef PATTERN_TSTAMP_EN
        output evt_ts,
`endif
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_vec,
`ifdef PATTERN_TSTAMP_EN
        input  evt_ts,
`endif
        output evt_ready
    );
endinterface

// File: rtl/pattern_evt_capture_fifo.sv
// Synchronous FIFO for capture events; pointers carry an extra MSB so
// full/empty/level fall out of a plain subtraction.
module pattern_evt_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop on a full FIFO frees the head slot, which the push then reuses.
    assign do_push = push && (!full || do_pop);
    assign level   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/pattern_evt_capture.sv
// Samples the pattern vector each clock and queues one event per changed cycle.
// Define PATTERN_TSTAMP_EN to store a free-running timestamp with each event.
module pattern_evt_capture
    import pattern_cap_pkg::*;
#(
    parameter int VEC_W  = CAP_VEC_W,
    parameter int DEPTH  = CAP_DEPTH,
    parameter int TS_W   = CAP_TS_W,
    parameter int DROP_W = CAP_DROP_W
) (
    input  logic                   blif_clk_net,
    input  logic                   blif_reset_net,
    input  logic [VEC_W-1:0]       pat_in,
    input  logic                   cap_en,
    pattern_evt_capture_if.master  evt,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic [DROP_W-1:0]      drop_cnt
);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pattern_evt_capture: DEPTH must be a power of two >= 2");
    end
    if (TS_W < 1) begin : g_bad_ts
        $error("pattern_evt_capture: TS_W must be >= 1");
    end

`ifdef PATTERN_TSTAMP_EN
    localparam int ENT_W = VEC_W + TS_W;
`else
    localparam int ENT_W = VEC_W;
`endif

    cap_state_e       state, state_nxt;
    logic [VEC_W-1:0] pat_q, pat_prev;
    logic             push_req, pop, full, empty, drop;
    logic [ENT_W-1:0] wdata, rdata;

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) state <= IDLE;
        else                 state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!cap_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = PRIME;
                PRIME:   state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    // PRIME only takes a baseline so a re-enable never compares against a stale vector.
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            pat_q    <= '0;
            pat_prev <= '0;
        end else begin
            pat_q <= pat_in;
            if (state != IDLE) pat_prev <= pat_q;
        end
    end

    assign push_req = (state == RUN) && (pat_q != pat_prev);
    assign pop      = !empty && evt.evt_ready;
    assign drop     = push_req && full && !pop;

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

`ifdef PATTERN_TSTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) ts_cnt <= '0;
        else                 ts_cnt <= ts_cnt + TS_W'(1);
    end

    assign wdata      = {ts_cnt, pat_q};
    assign evt.evt_ts = rdata[ENT_W-1:VEC_W];
`else
    assign wdata = pat_q;
`endif

    assign evt.evt_vec   = rdata[VEC_W-1:0];
    assign evt.evt_valid = !empty;

    pattern_evt_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (blif_clk_net),
        .rst_n (blif_reset_net),
        .push  (push_req),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );
endmodule
